// File: rtl/aes_inv_key_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : aes_inv_key_sched                                              |
// | Purpose : AES-128 inverse key scheduler. Emits round keys 10 down to 0   |
// |           by running the key expansion backwards one step per handshake. |
// |           Optional macro FWD_EXPAND_EN: key_in is the cipher key and the  |
// |           round-10 key is first built by ten forward steps.              |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module aes_inv_key_sched #(
    parameter int         NUM_ROUNDS = 10,
    parameter logic [7:0] RCON_LAST  = 8'h36
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_num,
    output logic         done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OUT  = 2'd2;
`ifdef FWD_EXPAND_EN
    localparam logic [1:0] S_PREP = 2'd1;
`endif

    localparam logic [7:0] C_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic [1:0]   r_state;
    logic [7:0]   r_rcon;
    logic [31:0]  w_k0, w_k1, w_k2, w_k3;
    logic [31:0]  w_b0, w_b1, w_b2, w_b3;
    logic [31:0]  w_sub_in, w_rot, w_sub, w_t;
    logic [127:0] w_prev_key;
    logic [8:0]   w_rc9;
    logic [7:0]   w_inv_xtime;

    assign {w_k0, w_k1, w_k2, w_k3} = round_key;

    // Backward step: the earlier key's last three words fall out of XORs of
    // neighbours, and its word 3 feeds the RotWord/SubWord term for word 0.
    assign w_b3 = w_k3 ^ w_k2;
    assign w_b2 = w_k2 ^ w_k1;
    assign w_b1 = w_k1 ^ w_k0;

`ifdef FWD_EXPAND_EN
    logic [31:0]  w_f0, w_f1, w_f2, w_f3;
    logic [7:0]   w_xtime;

    // One S-box bank serves both directions; PREP feeds the current word 3.
    assign w_sub_in = (r_state == S_PREP) ? w_k3 : w_b3;
    assign w_f0     = w_k0 ^ w_t;
    assign w_f1     = w_k1 ^ w_f0;
    assign w_f2     = w_k2 ^ w_f1;
    assign w_f3     = w_k3 ^ w_f2;
    assign w_xtime  = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
`else
    assign w_sub_in = w_b3;
`endif

    assign w_rot = {w_sub_in[23:0], w_sub_in[31:24]};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
        assign w_sub[gi*8 +: 8] = C_SBOX[w_rot[gi*8 +: 8]];
    end

    assign w_t        = w_sub ^ {r_rcon, 24'h000000};
    assign w_b0       = w_k0 ^ w_t;
    assign w_prev_key = {w_b0, w_b1, w_b2, w_b3};

    assign w_rc9       = r_rcon[0] ? ({1'b0, r_rcon} ^ 9'h11b) : {1'b0, r_rcon};
    assign w_inv_xtime = w_rc9[8:1];

    assign busy     = (r_state != S_IDLE);
    assign rk_valid = (r_state == S_OUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rcon    <= 8'h00;
            round_key <= '0;
            round_num <= 4'd0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        round_key <= key_in;
`ifdef FWD_EXPAND_EN
                        r_state   <= S_PREP;
                        round_num <= 4'd0;
                        r_rcon    <= 8'h01;
`else
                        r_state   <= S_OUT;
                        round_num <= 4'(NUM_ROUNDS);
                        r_rcon    <= RCON_LAST;
`endif
                    end
                end
`ifdef FWD_EXPAND_EN
                S_PREP: begin
                    round_key <= {w_f0, w_f1, w_f2, w_f3};
                    if (round_num == 4'(NUM_ROUNDS - 1)) begin
                        round_num <= 4'(NUM_ROUNDS);
                        r_rcon    <= RCON_LAST;
                        r_state   <= S_OUT;
                    end else begin
                        round_num <= round_num + 4'd1;
                        r_rcon    <= w_xtime;
                    end
                end
`endif
                S_OUT: begin
                    if (rk_ready) begin
                        if (round_num != 4'd0) begin
                            round_key <= w_prev_key;
                            round_num <= round_num - 4'd1;
                            r_rcon    <= w_inv_xtime;
                        end else begin
                            r_state <= S_IDLE;
                            done    <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/aes_inv_key_sched.md
Name: aes_inv_key_sched

Overview:
- AES-128 inverse key scheduler for the decryption datapath.
- Loads the round-10 key and produces round keys in reverse order, 10 down to 0, one per accepted handshake.
- Each earlier key is derived on the fly by running the key-expansion recurrence backwards, so no 11-entry key RAM is needed.
- Sits between the key-load interface and the inverse-cipher round engine.

Parameters:
NUM_ROUNDS, 10, final round index; fixed to 10 for AES-128; other values are unsupported.
RCON_LAST, 8'h36, round constant used to step back from round NUM_ROUNDS.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  load key_in and begin a sequence; honoured only in IDLE
key_in  input  128  round-10 key, or the cipher key when FWD_EXPAND_EN is defined; word 0 = [127:96]
busy  output  1  high in any state other than IDLE
rk_valid  output  1  round_key / round_num are valid
rk_ready  input  1  consumer accepts the current round key
round_key  output  128  current round key
round_num  output  4  index of round_key, 10..0
done  output  1  one-cycle pulse after round 0 is accepted

Behaviour:
- Reset values: state IDLE; busy=0, rk_valid=0, done=0, round_key=0, round_num=0, rcon=8'h00.
- States: IDLE, PREP (only with FWD_EXPAND_EN), OUT.
- IDLE, start=1:
  - round_key<=key_in, round_num<=10, rcon<=RCON_LAST.
  - Next state OUT.
  - rk_valid rises on the next cycle, i.e. 1-cycle latency from start.
- OUT:
  - rk_valid=1. round_key and round_num hold stable while rk_ready=0.
  - Handshake rk_valid&rk_ready with round_num>0:
    - round_key<=prev(round_key), round_num<=round_num-1, rcon<=inv_xtime(rcon).
    - rk_valid stays high, so throughput is one key per cycle under continuous rk_ready.
  - Handshake with round_num==0:
    - next state IDLE, rk_valid<=0.
    - done=1 for exactly one cycle.
    - round_key and round_num keep their last values.
- prev(), with input words n0..n3 and outputs k0..k3:
  - k3=n3^n2, k2=n2^n1, k1=n1^n0.
  - k0 = n0 ^ SubWord(RotWord(k3)) ^ {rcon,24'h0}.
  - RotWord rotates bytes left by one: {b1,b2,b3,b0}.
  - SubWord is four parallel forward AES S-box byte lookups; the inverse S-box is not used.
- inv_xtime(x): if x[0]==1 then (x ^ 9'h11b)>>1, else x>>1.
  - Sequence: 36,1b,80,40,20,10,08,04,02,01.
- start while busy: ignored; no restart and no effect on the in-flight sequence.
- start and rst asserted in the same cycle: rst wins, state IDLE.
- rst mid-sequence: the next cycle is IDLE with all outputs at reset values, with no partial done pulse.
- rk_ready while rk_valid=0: ignored.

Optional Feature:
- Macro: FWD_EXPAND_EN.
- Defined:
  - key_in is the cipher key (round 0).
  - IDLE+start goes to PREP, loads round_num=0 and rcon=8'h01, and holds rk_valid=0 and busy=1.
  - PREP applies one forward step per cycle:
    - n0 = k0 ^ SubWord(RotWord(k3)) ^ {rcon,24'h0}, n1=k1^n0, n2=k2^n1, n3=k3^n2.
    - round_num increments; rcon<=xtime(rcon).
  - After 10 steps: round_num=10, rcon=8'h36, state OUT.
  - Latency from start to rk_valid is 11 cycles.
  - Forward and backward paths share a single 4-byte S-box lookup through an input mux.
- Not defined:
  - The PREP state and forward logic are absent.
  - key_in must be the round-10 key; latency from start to rk_valid is 1 cycle.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, macro off: start with key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, rk_ready=1 -> 11 consecutive valid cycles.
  - round 10 key = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - round 9 = ac7766f319fadc2128d12941575c006e.
  - round 1 = a0fafe1788542cb123a339392a6c7605.
  - round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - done pulses once, then busy=0.
- Backpressure: toggle rk_ready randomly, with a 5-cycle stall at round 9 -> round_key and round_num stable while stalled; same 11-key sequence; no key skipped or duplicated.
- start pulsed at round 6 while busy -> ignored; sequence completes to round 0 unchanged.
- rst asserted at round 4 -> next cycle rk_valid=0, busy=0, round_num=0, done=0. A following start with the round-10 key restarts cleanly at round 10.
- Macro on: start with key_in=2b7e151628aed2a6abf7158809cf4f3c -> rk_valid rises 11 cycles after start with round_key=d014f9a8c9ee2589e13f0cc8b6630ca6, then the same reverse sequence as the first scenario.
- All-zero round-10 key, macro off -> rcon observed as 36,1b,80,...,01 across steps; round 0 output matches a software model of inverse expansion.
